// File: rtl/output_drain.sv
// Output drain: buffers completed output-feature-map words in a small FIFO for the host
// and flags the end of a layer once every expected word has been pushed and drained.
module output_drain #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
  input  logic                          clk,
  input  logic                          arst_in,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [31:0]                   in_x,
  input  logic [31:0]                   in_y,
  input  logic [31:0]                   in_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [31:0]                   out_x,
  output logic [31:0]                   out_y,
  output logic [31:0]                   out_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          layer_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [63:0] TOTAL = 64'(FEATURE_MAP_WIDTH) * 64'(FEATURE_MAP_HEIGHT)
                                * 64'(OUTPUT_NB_CHANNELS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [63:0]   push_cnt_q, push_cnt_d;
  logic [63:0]   pop_cnt_q, pop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          layer_done_q, layer_done_d;

  logic          pop;
  logic          push;
  logic          full;
  logic          clear;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];

    pop   = (level_q != '0) && out_ready;
    full  = (level_q == LW'(FIFO_DEPTH));
    push  = 1'b0;
    clear = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (push_cnt_q == TOTAL && level_q == '0) state_d = DONE;
        // A dropped word still counts toward the layer total.
        if (in_valid) begin
          push_cnt_d = push_cnt_q + 64'd1;
          if (!full || pop) begin
            push                = 1'b1;
            mem_d[wr_ptr_q]     = '{data: in_data, x: in_x, y: in_y, ch: in_ch};
            wr_ptr_d            = wr_ptr_q + AW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      pop_cnt_d = pop_cnt_q + 64'd1;
    end

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      push_cnt_d = '0;
      pop_cnt_d  = '0;
      overflow_d = 1'b0;
    end

    layer_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      push_cnt_q   <= '0;
      pop_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      layer_done_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      overflow_q   <= overflow_d;
      layer_done_q <= layer_done_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Head is shown combinationally; forced to zero while the buffer is empty.
  always_comb begin
    out_valid  = (level_q != '0);
    out_data   = '0;
    out_x      = '0;
    out_y      = '0;
    out_ch     = '0;
    if (out_valid) begin
      out_data = mem_q[rd_ptr_q].data;
      out_x    = mem_q[rd_ptr_q].x;
      out_y    = mem_q[rd_ptr_q].y;
      out_ch   = mem_q[rd_ptr_q].ch;
    end
    fifo_level = level_q;
    overflow   = overflow_q;
    layer_done = layer_done_q;
  end

endmodule

// File: tb/tb_output_drain.sv
// Scoreboard bench for output_drain: stimulus updates a queue-based model per clock edge,
// a negedge monitor pops expected words whenever the DUT hands one to the host.
module tb_output_drain;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TOTAL = 2 * 2 * 2;

  logic        clk = 1'b0;
  logic        arst_in = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [31:0] in_x = '0, in_y = '0, in_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [31:0] out_x, out_y, out_ch;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        layer_done;

  output_drain #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FEATURE_MAP_WIDTH(2),
    .FEATURE_MAP_HEIGHT(2),
    .OUTPUT_NB_CHANNELS(2)
  ) dut (
    .clk(clk), .arst_in(arst_in), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .fifo_level(fifo_level),
    .overflow(overflow), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d, x, y, c; } word_t;
  word_t sb[$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  m_run = 0, m_done = 0, m_ov = 0;
  int  m_lvl = 0, m_pushes = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void m_clear();
    m_lvl = 0; m_pushes = 0; m_ov = 0;
    sb.delete();
  endfunction

  // Behavioural effect of one rising edge given the inputs currently applied.
  function automatic void model_edge();
    bit popping;
    bit drain_done;
    popping = (m_lvl > 0) && out_ready;
    drain_done = (m_pushes == TOTAL) && (m_lvl == 0);
    if (m_run) begin
      if (in_valid) begin
        m_pushes++;
        if (m_lvl < DEPTH || popping) begin
          sb.push_back('{in_data, in_x, in_y, in_ch});
          m_lvl++;
        end else m_ov = 1;
      end
      if (popping) m_lvl--;
      if (drain_done) begin m_run = 0; m_done = 1; end
    end else if (start) begin
      m_run = 1; m_done = 0;
      m_clear();
    end
  endfunction

  task automatic cyc(input bit s, input bit v, input logic [31:0] d, input bit r);
    start = s; in_valid = v; in_data = d; out_ready = r;
    in_x = $urandom; in_y = $urandom; in_ch = $urandom;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    arst_in = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_coords", {out_x, out_y, out_ch}, 0);
    m_run = 0; m_done = 0;
    m_clear();
    start = 0; in_valid = 0;
    @(posedge clk);
    #1;
    arst_in = 1'b0;
  endtask

  always @(negedge clk) begin
    word_t e;
    chk("out_valid", out_valid, m_lvl != 0);
    chk("fifo_level", fifo_level, m_lvl);
    chk("overflow", overflow, m_ov);
    chk("layer_done", layer_done, m_done);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL pop_unexpected at %0t: got data %0d, expected no word", $time, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_x", out_x, e.x);
        chk("out_y", out_y, e.y);
        chk("out_ch", out_ch, e.c);
      end
    end
  end

  initial begin
    int guard;
    bit v, r, s;
    #3;
    do_reset();

    // IDLE ignores in_valid
    cyc(0, 1, 99, 1);
    cyc(0, 0, 0, 1);

    // Straight-through layer 1..8
    cyc(1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) cyc(0, 1, i, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("done_after_stream", layer_done, 1);
    cyc(0, 1, 55, 1);   // ignored in DONE

    // Re-arm from DONE, fill past capacity
    cyc(1, 0, 0, 0);
    chk("rearm_layer_done", layer_done, 0);
    for (int i = 10; i <= 14; i++) cyc(0, 1, i, 0);
    chk("sat_level", fifo_level, 4);
    chk("sat_overflow", overflow, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("drained_level", fifo_level, 0);

    // Simultaneous push/pop while full
    do_reset();
    cyc(1, 0, 0, 0);
    for (int i = 20; i < 24; i++) cyc(0, 1, i, 0);
    cyc(0, 1, 24, 1);
    chk("full_pushpop_level", fifo_level, 4);
    chk("full_pushpop_ovf", overflow, 0);
    chk("full_pushpop_head", out_data, 21);
    for (int i = 25; i < 28; i++) cyc(0, 1, i, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("done_pushpop", layer_done, 1);

    // Reset mid-run with buffered words
    cyc(1, 0, 0, 0);
    for (int i = 30; i < 33; i++) cyc(0, 1, i, 0);
    do_reset();
    cyc(0, 1, 77, 1);   // IDLE after release: ignored
    chk("post_rst_level", fifo_level, 0);

    // Randomized layers, including stray start pulses during RUN
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, $urandom_range(0, 1));
      guard = 0;
      while (!m_done && guard < 300) begin
        s = ($urandom_range(0, 15) == 0);
        v = (m_pushes < TOTAL) && ($urandom_range(0, 1) == 1);
        r = (m_pushes >= TOTAL) || ($urandom_range(0, 3) != 0);
        cyc(s, v, $urandom, r);
        guard++;
      end
      if (!m_done) begin
        n_vec++; n_err++;
        $display("FAIL layer_timeout: got layer_done %0d after %0d cycles, expected 1", layer_done, guard);
      end
      cyc(0, 0, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
